// File: rtl/ps2_keycode_rx_if.sv
//==============================================================================
// Module      : ps2_keycode_rx_if
// Description : Bundle of the PS/2 keyboard pins and the keycode receiver
//               results.
//               master : drives the PS/2 pins and observes the results
//                        (board side / testbench).
//               slave  : the receiver samples the pins and drives the
//                        results.
//               Signals:
//                 PS2_CLK    1  keyboard clock, asynchronous, idle high
//                 PS2_DAT    1  keyboard data, asynchronous
//                 keycode    8  HID code of the selected held direction key
//                 byte_valid 1  one-cycle pulse, good frame received
//                 scan_byte  8  last good raw scancode byte
//                 frame_err  1  one-cycle pulse, framing/parity/timeout error
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ps2_keycode_rx_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] keycode;
  logic       byte_valid;
  logic [7:0] scan_byte;
  logic       frame_err;

  modport master (
    output PS2_CLK, PS2_DAT,
    input  keycode, byte_valid, scan_byte, frame_err
  );

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output keycode, byte_valid, scan_byte, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_keycode_rx.sv
//==============================================================================
// Module      : ps2_keycode_rx
// Description : PS/2 keyboard receiver (scancode set 2) producing the held
//               HID direction keycode: 04 left, 1A up, 07 right, 16 down,
//               00 none. WASD and the arrow keys map to the same codes.
//               Ports:
//                 Clk    in  system clock (50 MHz)
//                 Reset  in  synchronous, active-high
//                 bus    ps2_keycode_rx_if.slave (pins in, results out)
//               Parameters:
//                 FILTER_LEN     consecutive samples to accept a PS2_CLK edge
//                 TIMEOUT_CYCLES idle cycles mid-frame before abort
//               Build option:
//                 PS2_PARITY_CHECK_EN  defined   -> odd parity enforced
//                                      undefined -> parity bit ignored
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  ps2_keycode_rx_if.slave       bus
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXTBRK} dec_state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers and PS2_CLK glitch filter
  // ---------------------------------------------------------------------------
  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic          filt_accept;
  logic          clk_fall;

  // A new level is taken only after FILTER_LEN consecutive samples disagree
  // with the filtered level.
  assign filt_accept = (clk_sync_q != filt_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
  assign clk_fall    = filt_accept && !clk_sync_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_meta_q <= bus.PS2_CLK;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= bus.PS2_DAT;
      dat_sync_q <= dat_meta_q;
      if (clk_sync_q == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_accept) begin
        filt_q     <= clk_sync_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  rx_state_t     rx_state_q, rx_state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    scan_byte_q, scan_byte_d;
  logic          frame_err_q, frame_err_d;
  logic          par_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  assign par_ok = ^{shift_q, par_q};   // data + parity must have odd weight
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      scan_byte_q  <= '0;
      frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= 1'b0;
`endif
    end else begin
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      scan_byte_q  <= scan_byte_d;
      frame_err_q  <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= par_d;
`endif
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    scan_byte_d  = scan_byte_q;
    frame_err_d  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d        = par_q;
`endif
    tmo_d = ((rx_state_q == RX_IDLE) || clk_fall) ? '0 : tmo_q + TW'(1);

    case (rx_state_q)
      RX_IDLE: begin
        // A fall with data high is not a start bit; it is simply ignored.
        if (clk_fall && !dat_sync_q) begin
          rx_state_d = RX_DATA;
          bit_cnt_d  = 3'd0;
        end
      end
      RX_DATA: begin
        if (clk_fall) begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (clk_fall) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat_sync_q;
`endif
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_fall) begin
          rx_state_d = RX_IDLE;
          if (dat_sync_q && par_ok) begin
            byte_valid_d = 1'b1;
            scan_byte_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // A stalled frame is abandoned; the partial byte is never published.
    if ((rx_state_q != RX_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES))) begin
      rx_state_d   = RX_IDLE;
      tmo_d        = '0;
      frame_err_d  = 1'b1;
      byte_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode FSM, held mask and keycode selection
  // ---------------------------------------------------------------------------
  dec_state_t dec_state_q, dec_state_d;
  logic [3:0] held_q, held_d;        // bit 0 L, 1 U, 2 R, 3 D
  logic [1:0] last_q, last_d;
  logic [7:0] keycode_q, keycode_d;
  logic       do_make, do_break, is_ext;
  logic [2:0] hit;                   // {mapped, index}

  function automatic logic [2:0] lookup(input logic [7:0] code, input logic ext);
    lookup = 3'b000;
    if (!ext) begin
      case (code)
        8'h1C:   lookup = 3'b100;
        8'h1D:   lookup = 3'b101;
        8'h23:   lookup = 3'b110;
        8'h1B:   lookup = 3'b111;
        default: lookup = 3'b000;
      endcase
    end else begin
      case (code)
        8'h6B:   lookup = 3'b100;
        8'h75:   lookup = 3'b101;
        8'h74:   lookup = 3'b110;
        8'h72:   lookup = 3'b111;
        default: lookup = 3'b000;
      endcase
    end
  endfunction

  function automatic logic [7:0] hid(input logic [1:0] idx);
    case (idx)
      2'd0:    hid = 8'h04;
      2'd1:    hid = 8'h1A;
      2'd2:    hid = 8'h07;
      default: hid = 8'h16;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      dec_state_q <= D_IDLE;
      held_q      <= '0;
      last_q      <= '0;
      keycode_q   <= '0;
    end else begin
      dec_state_q <= dec_state_d;
      held_q      <= held_d;
      last_q      <= last_d;
      keycode_q   <= keycode_d;
    end
  end

  always_comb begin
    dec_state_d = dec_state_q;
    held_d      = held_q;
    last_d      = last_q;
    do_make     = 1'b0;
    do_break    = 1'b0;
    is_ext      = 1'b0;

    if (byte_valid_q) begin
      case (dec_state_q)
        D_IDLE: begin
          if (scan_byte_q == 8'hE0)      dec_state_d = D_EXT;
          else if (scan_byte_q == 8'hF0) dec_state_d = D_BRK;
          else                           do_make     = 1'b1;
        end
        D_EXT: begin
          if (scan_byte_q == 8'hF0) begin
            dec_state_d = D_EXTBRK;
          end else if (scan_byte_q != 8'hE0) begin
            do_make     = 1'b1;
            is_ext      = 1'b1;
            dec_state_d = D_IDLE;
          end
        end
        D_BRK: begin
          if (scan_byte_q != 8'hF0) begin
            do_break    = 1'b1;
            dec_state_d = D_IDLE;
          end
        end
        default: begin
          if ((scan_byte_q != 8'hE0) && (scan_byte_q != 8'hF0)) begin
            do_break    = 1'b1;
            is_ext      = 1'b1;
            dec_state_d = D_IDLE;
          end
        end
      endcase
    end

    hit = lookup(scan_byte_q, is_ext);
    if (hit[2] && do_make) begin
      held_d[hit[1:0]] = 1'b1;
      last_d           = hit[1:0];
    end
    if (hit[2] && do_break) held_d[hit[1:0]] = 1'b0;

    // "last" released: fall back to the lowest-index key still held.
    if (!held_d[last_d]) begin
      casez (held_d)
        4'b???1: last_d = 2'd0;
        4'b??10: last_d = 2'd1;
        4'b?100: last_d = 2'd2;
        4'b1000: last_d = 2'd3;
        default: last_d = last_d;
      endcase
    end

    keycode_d = held_d[last_d] ? hid(last_d) : 8'h00;
  end

  assign bus.keycode    = keycode_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.scan_byte  = scan_byte_q;
  assign bus.frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keycode_rx.sv
//==============================================================================
// Module      : tb_ps2_keycode_rx
// Description : Self-checking bench for ps2_keycode_rx. PS/2 frames are
//               driven bit by bit; each frame pushes its expected outcome
//               (good byte or error) into a scoreboard that a monitor pops
//               on every byte_valid / frame_err pulse. Keycode results are
//               checked directly after each key action.
//               Build option PS2_PARITY_CHECK_EN selects expected parity
//               behaviour.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ps2_keycode_rx;

  localparam int HALF    = 20;      // Clk cycles per PS/2 clock half period
  localparam int TIMEOUT = 50000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic Clk;
  logic Reset;

  ps2_keycode_rx_if ifc ();

  ps2_keycode_rx #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifc.slave)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  typedef struct {
    bit         err;
    logic [7:0] b;
  } exp_t;

  exp_t sbq[$];
  int   checks    = 0;
  int   errors    = 0;
  int   bv_count  = 0;
  int   err_count = 0;
  int   bv_exp    = 0;
  int   err_exp   = 0;
  logic [7:0] kc_at_bv    = 8'h00;
  logic [7:0] kc_after_bv = 8'h00;
  logic       bv_prev     = 1'b0;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    if (!Reset) begin
      if (bv_prev) kc_after_bv = ifc.keycode;
      if (ifc.byte_valid) begin
        bv_count++;
        kc_at_bv = ifc.keycode;
        checks++;
        assert (sbq.size() > 0) else begin
          errors++;
          $error("FAIL sb_unexpected_byte: observed byte %h expected no pulse", ifc.scan_byte);
        end
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chki("sb_kind_byte", 0, int'(e.err));
          chk8("sb_scan_byte", ifc.scan_byte, e.b);
        end
      end
      if (ifc.frame_err) begin
        err_count++;
        checks++;
        assert (sbq.size() > 0) else begin
          errors++;
          $error("FAIL sb_unexpected_err: observed frame_err expected no pulse");
        end
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chki("sb_kind_err", 1, int'(e.err));
        end
      end
      bv_prev = ifc.byte_valid;
    end else begin
      bv_prev = 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_bit(input logic v);
    ifc.PS2_DAT = v;
    cycles(HALF);
    ifc.PS2_CLK = 1'b0;
    cycles(HALF);
    ifc.PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop);
    exp_t e;
    logic par;
    par   = ~(^b) ^ bad_par;
    e.err = (stop == 1'b0) || (bad_par && PARITY_ON);
    e.b   = e.err ? 8'h00 : b;
    sbq.push_back(e);
    if (e.err) err_exp++; else bv_exp++;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop);
    ifc.PS2_DAT = 1'b1;
    cycles(HALF);
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  initial begin
    int bv0;
    int e0;
    int waited;
    ifc.PS2_CLK = 1'b1;
    ifc.PS2_DAT = 1'b1;
    Reset = 1'b1;
    cycles(5);
    Reset = 1'b0;
    cycles(2);
    chk8("reset_keycode", ifc.keycode, 8'h00);
    chki("reset_byte_valid", int'(ifc.byte_valid), 0);
    chki("reset_frame_err", int'(ifc.frame_err), 0);

    // Single make: keycode follows one cycle after byte_valid
    bv0 = bv_count;
    key(8'h1C);
    chk8("t1_kc_at_bv", kc_at_bv, 8'h00);
    chk8("t1_kc_after_bv", kc_after_bv, 8'h04);
    chk8("t1_keycode", ifc.keycode, 8'h04);

    // Break of the same key
    key(8'hF0); key(8'h1C);
    chk8("t2_keycode", ifc.keycode, 8'h00);
    chki("t2_bv_pulses", bv_count - bv0, 3);
    chki("t2_no_err", err_count, 0);

    // Extended up arrow
    key(8'hE0); key(8'h75);
    chk8("t3_make_up", ifc.keycode, 8'h1A);
    key(8'hE0); key(8'hF0); key(8'h75);
    chk8("t3_break_up", ifc.keycode, 8'h00);

    // Two keys held, last wins, release order
    key(8'h1C); key(8'h23);
    chk8("t4_left_right", ifc.keycode, 8'h07);
    key(8'hF0); key(8'h23);
    chk8("t4_rel_right", ifc.keycode, 8'h04);
    key(8'hF0); key(8'h1C);
    chk8("t4_rel_left", ifc.keycode, 8'h00);

    // Typematic repeat re-selects; fallback picks lowest held index
    key(8'h1B); key(8'h1D); key(8'h1B);
    chk8("typematic", ifc.keycode, 8'h16);
    key(8'hF0); key(8'h1B);
    chk8("fallback_up", ifc.keycode, 8'h1A);
    key(8'hE0); key(8'hE0); key(8'h6B);
    chk8("dup_prefix_left", ifc.keycode, 8'h04);
    key(8'hF0); key(8'hF0); key(8'h1D);
    key(8'hE0); key(8'hF0); key(8'h6B);
    chk8("all_released", ifc.keycode, 8'h00);

    // Bad parity
    send_frame(8'h1C, 1'b1, 1'b1);
    chk8("t5_bad_parity_kc", ifc.keycode, PARITY_ON ? 8'h00 : 8'h04);
    if (!PARITY_ON) begin
      key(8'hF0); key(8'h1C);
    end

    // Bad stop bit, and a prefix surviving an error
    send_frame(8'h1D, 1'b0, 1'b0);
    chk8("bad_stop_kc", ifc.keycode, 8'h00);
    key(8'hE0);
    send_frame(8'h33, 1'b0, 1'b0);
    key(8'h75);
    chk8("prefix_after_err", ifc.keycode, 8'h1A);
    key(8'hE0); key(8'hF0); key(8'h75);
    chk8("prefix_release", ifc.keycode, 8'h00);

    // Timeout after 5 data bits
    begin
      exp_t e;
      e.err = 1'b1;
      e.b   = 8'h00;
      sbq.push_back(e);
      err_exp++;
    end
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    e0 = err_count;
    waited = 0;
    while ((err_count == e0) && (waited < TIMEOUT + 2000)) begin
      cycles(1);
      waited++;
    end
    chki("t6_timeout_seen", err_count - e0, 1);
    checks++;
    assert ((waited >= TIMEOUT - 60) && (waited <= TIMEOUT + 40)) else begin
      errors++;
      $error("FAIL t6_timeout_latency: observed %0d cycles expected about %0d", waited, TIMEOUT - HALF);
    end
    key(8'h1D);
    chk8("t6_after_timeout", ifc.keycode, 8'h1A);
    key(8'hF0); key(8'h1D);

    // Short glitch on PS2_CLK while idle, data low
    bv0 = bv_count;
    e0  = err_count;
    ifc.PS2_DAT = 1'b0;
    cycles(3);
    ifc.PS2_CLK = 1'b0;
    cycles(2);
    ifc.PS2_CLK = 1'b1;
    cycles(3);
    ifc.PS2_DAT = 1'b1;
    cycles(30);
    chki("t7_glitch_no_bv", bv_count - bv0, 0);
    chki("t7_glitch_no_err", err_count - e0, 0);
    key(8'h1B);
    chk8("t7_after_glitch", ifc.keycode, 8'h16);

    // Reset in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    Reset = 1'b1;
    cycles(3);
    Reset = 1'b0;
    cycles(2);
    chk8("mid_reset_kc", ifc.keycode, 8'h00);
    key(8'h1C);
    chk8("after_reset_kc", ifc.keycode, 8'h04);

    cycles(20);
    chki("sb_drained", sbq.size(), 0);
    chki("total_bv", bv_count, bv_exp);
    chki("total_err", err_count, err_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
